// File: rtl/gray_to_binary_sync.sv
// gray_to_binary_sync
//   Synchronizes an asynchronous gray-coded count into the clk domain,
//   decodes it to binary and reports step direction, wrap-around and
//   illegal (multi-bit) gray transitions.
//
// Ports
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   g        in   [WIDTH] gray count, asynchronous to clk
//   clr      in   synchronous clear of err
//   b        out  [WIDTH] registered binary decode of synchronized g
//   b_valid  out  one-cycle pulse when b takes a new value while tracking
//   dir      out  last step direction (1 = up, 0 = down)
//   wrap     out  one-cycle pulse on a max->0 or 0->max step
//   err      out  sticky flag for an illegal multi-bit gray change
//
// Configuration
//   GRAY_ERR_CHECK_EN  when defined, builds the Hamming-distance check
//                      driving err; otherwise err is tied low and clr
//                      is ignored.

module gray_to_binary_sync #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] g,
    input  logic             clr,
    output logic [WIDTH-1:0] b,
    output logic             b_valid,
    output logic             dir,
    output logic             wrap,
    output logic             err
);

    typedef enum logic {
        ST_INIT,
        ST_TRACK
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [1:0]       r_init_cnt;
    logic [1:0]       w_init_cnt_nxt;
    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s2;
    logic [WIDTH-1:0] r_last_g;
    logic [WIDTH-1:0] w_last_g_nxt;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] w_b_nxt;
    logic             r_b_valid;
    logic             w_b_valid_nxt;
    logic             r_dir;
    logic             w_dir_nxt;
    logic             r_wrap;
    logic             w_wrap_nxt;
    logic [WIDTH-1:0] w_bin;
    logic [WIDTH-1:0] w_b_inc;
    logic [WIDTH-1:0] w_b_dec;

    // bin[i] is the XOR of all gray bits at or above i.
    always_comb begin
        w_bin = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            w_bin[i] = ^(r_s2 >> i);
        end
    end

    always_comb begin
        w_b_inc = r_b + WIDTH'(1);
        w_b_dec = r_b - WIDTH'(1);
    end

    // Next-state / next-output logic.
    always_comb begin
        w_state_nxt    = r_state;
        w_init_cnt_nxt = r_init_cnt;
        w_b_nxt        = r_b;
        w_last_g_nxt   = r_last_g;
        w_b_valid_nxt  = 1'b0;
        w_dir_nxt      = r_dir;
        w_wrap_nxt     = 1'b0;
        case (r_state)
            ST_INIT: begin
                // Two edges fill s1/s2; the third edge loads b from s2.
                if (r_init_cnt == 2'd2) begin
                    w_b_nxt        = w_bin;
                    w_last_g_nxt   = r_s2;
                    w_init_cnt_nxt = '0;
                    w_state_nxt    = ST_TRACK;
                end else begin
                    w_init_cnt_nxt = r_init_cnt + 2'd1;
                end
            end
            ST_TRACK: begin
                if (r_s2 != r_last_g) begin
                    w_b_nxt       = w_bin;
                    w_last_g_nxt  = r_s2;
                    w_b_valid_nxt = 1'b1;
                    if (w_bin == w_b_inc) begin
                        w_dir_nxt = 1'b1;
                    end else if (w_bin == w_b_dec) begin
                        w_dir_nxt = 1'b0;
                    end
                    w_wrap_nxt = ((r_b == '1) && (w_bin == '0)) ||
                                 ((r_b == '0) && (w_bin == '1));
                end
            end
            default: begin
                w_state_nxt = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1       <= '0;
            r_s2       <= '0;
            r_state    <= ST_INIT;
            r_init_cnt <= '0;
            r_last_g   <= '0;
            r_b        <= '0;
            r_b_valid  <= 1'b0;
            r_dir      <= 1'b1;
            r_wrap     <= 1'b0;
        end else begin
            r_s1       <= g;
            r_s2       <= r_s1;
            r_state    <= w_state_nxt;
            r_init_cnt <= w_init_cnt_nxt;
            r_last_g   <= w_last_g_nxt;
            r_b        <= w_b_nxt;
            r_b_valid  <= w_b_valid_nxt;
            r_dir      <= w_dir_nxt;
            r_wrap     <= w_wrap_nxt;
        end
    end

    assign b       = r_b;
    assign b_valid = r_b_valid;
    assign dir     = r_dir;
    assign wrap    = r_wrap;

`ifdef GRAY_ERR_CHECK_EN
    logic [WIDTH-1:0] w_diff;
    logic [4:0]       w_hd;
    logic             w_err_set;
    logic             r_err;

    always_comb begin
        w_diff = r_s2 ^ r_last_g;
        w_hd   = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            w_hd = w_hd + 5'(w_diff[i]);
        end
        w_err_set = (r_state == ST_TRACK) && (w_hd > 5'd1);
    end

    // A set in the same cycle as clr takes priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_err_set) begin
            r_err <= 1'b1;
        end else if (clr) begin
            r_err <= 1'b0;
        end
    end

    assign err = r_err;
`else
    logic w_unused_clr;

    assign w_unused_clr = clr;
    assign err          = 1'b0;
`endif

endmodule

// File: tb/tb_gray_to_binary_sync.sv
// tb_gray_to_binary_sync
//   Self-checking bench for gray_to_binary_sync (WIDTH=4). Table rows are
//   driven one per cycle; each row's expected outputs are queued and
//   compared after the third edge following the row. Reset sequences are
//   hand-written. err expectations follow GRAY_ERR_CHECK_EN.

module tb_gray_to_binary_sync;

    localparam int unsigned W = 4;

`ifdef GRAY_ERR_CHECK_EN
    localparam logic EE = 1'b1;
`else
    localparam logic EE = 1'b0;
`endif

    typedef struct {
        logic [W-1:0] g;
        logic         clr;
        logic [W-1:0] b;
        logic         bv;
        logic         dir;
        logic         wrap;
        logic         err;
    } vec_t;

    typedef struct {
        int           due;
        int           id;
        logic [W-1:0] b;
        logic         bv;
        logic         dir;
        logic         wrap;
        logic         err;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] g;
    logic         clr;
    logic [W-1:0] b;
    logic         b_valid;
    logic         dir;
    logic         wrap;
    logic         err;

    int   checks;
    int   errors;
    int   edge_cnt;
    vec_t tbl[$];
    exp_t sb[$];

    gray_to_binary_sync #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .g       (g),
        .clr     (clr),
        .b       (b),
        .b_valid (b_valid),
        .dir     (dir),
        .wrap    (wrap),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic add(input logic [W-1:0] gv, input logic c, input logic [W-1:0] bx,
                       input logic bvx, input logic dx, input logic wx, input logic ex);
        vec_t v;
        v.g = gv; v.clr = c; v.b = bx; v.bv = bvx; v.dir = dx; v.wrap = wx; v.err = ex;
        tbl.push_back(v);
    endtask

    task automatic push_exp(input int due, input int id, input logic [W-1:0] bx,
                            input logic bvx, input logic dx, input logic wx, input logic ex);
        exp_t e;
        e.due = due; e.id = id; e.b = bx; e.bv = bvx; e.dir = dx; e.wrap = wx; e.err = ex;
        sb.push_back(e);
    endtask

    task automatic drain();
        for (int i = 0; i < 12 && sb.size() != 0; i++) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, " b"}, 32'(b), 0);
        chk({tag, " b_valid"}, 32'(b_valid), 0);
        chk({tag, " dir"}, 32'(dir), 1);
        chk({tag, " wrap"}, 32'(wrap), 0);
        chk({tag, " err"}, 32'(err), 0);
    endtask

    // Scoreboard: compare queued expectations 1 time unit after their edge.
    initial begin
        edge_cnt = 0;
        forever begin
            @(posedge clk);
            edge_cnt++;
            #1;
            while (sb.size() != 0 && sb[0].due <= edge_cnt) begin
                exp_t e;
                e = sb.pop_front();
                if (e.due != edge_cnt) chk($sformatf("id%0d due", e.id), 32'(edge_cnt), 32'(e.due));
                chk($sformatf("id%0d b", e.id), 32'(b), 32'(e.b));
                chk($sformatf("id%0d b_valid", e.id), 32'(b_valid), 32'(e.bv));
                chk($sformatf("id%0d dir", e.id), 32'(dir), 32'(e.dir));
                chk($sformatf("id%0d wrap", e.id), 32'(wrap), 32'(e.wrap));
                chk($sformatf("id%0d err", e.id), 32'(err), 32'(e.err));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;

        //   g        clr   b        bv    dir   wrap  err
        for (int i = 0; i < 5; i++)
            add(4'b0111, 1'b0, 4'd5,  1'b0, 1'b1, 1'b0, 1'b0);   // INIT load, hold
        add(4'b0101, 1'b0, 4'd6,  1'b1, 1'b1, 1'b0, 1'b0);       // 5->6 up
        add(4'b0101, 1'b0, 4'd6,  1'b0, 1'b1, 1'b0, 1'b0);
        add(4'b0101, 1'b0, 4'd6,  1'b0, 1'b1, 1'b0, 1'b0);
        add(4'b0111, 1'b0, 4'd5,  1'b1, 1'b0, 1'b0, 1'b0);       // count down to 0
        add(4'b0110, 1'b0, 4'd4,  1'b1, 1'b0, 1'b0, 1'b0);
        add(4'b0010, 1'b0, 4'd3,  1'b1, 1'b0, 1'b0, 1'b0);
        add(4'b0011, 1'b0, 4'd2,  1'b1, 1'b0, 1'b0, 1'b0);
        add(4'b0001, 1'b0, 4'd1,  1'b1, 1'b0, 1'b0, 1'b0);
        add(4'b0000, 1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 1'b0);
        add(4'b1000, 1'b0, 4'd15, 1'b1, 1'b0, 1'b1, 1'b0);       // 0->15 wrap down
        add(4'b1000, 1'b0, 4'd15, 1'b0, 1'b0, 1'b0, 1'b0);
        add(4'b0000, 1'b0, 4'd0,  1'b1, 1'b1, 1'b1, 1'b0);       // 15->0 wrap up
        add(4'b0000, 1'b0, 4'd0,  1'b0, 1'b1, 1'b0, 1'b0);
        add(4'b1000, 1'b0, 4'd15, 1'b1, 1'b0, 1'b1, 1'b0);       // 0->15 wrap down
        add(4'b1000, 1'b0, 4'd15, 1'b0, 1'b0, 1'b0, 1'b0);
        add(4'b0000, 1'b0, 4'd0,  1'b1, 1'b1, 1'b1, 1'b0);
        add(4'b0000, 1'b0, 4'd0,  1'b0, 1'b1, 1'b0, 1'b0);
        add(4'b0011, 1'b0, 4'd2,  1'b1, 1'b1, 1'b0, EE);         // illegal 0->2, dir holds
        add(4'b0011, 1'b0, 4'd2,  1'b0, 1'b1, 1'b0, EE);
        add(4'b0011, 1'b0, 4'd2,  1'b0, 1'b1, 1'b0, EE);
        // err is observed two edges after a row, but clr acts on the row's
        // own edge, so the two rows before the clr row already see it cleared.
        add(4'b0011, 1'b0, 4'd2,  1'b0, 1'b1, 1'b0, 1'b0);
        add(4'b0011, 1'b0, 4'd2,  1'b0, 1'b1, 1'b0, 1'b0);
        add(4'b0011, 1'b1, 4'd2,  1'b0, 1'b1, 1'b0, 1'b0);       // clr
        add(4'b0011, 1'b0, 4'd2,  1'b0, 1'b1, 1'b0, 1'b0);
        add(4'b0000, 1'b0, 4'd0,  1'b1, 1'b1, 1'b0, EE);         // illegal 2->0
        add(4'b0000, 1'b0, 4'd0,  1'b0, 1'b1, 1'b0, EE);
        add(4'b0000, 1'b1, 4'd0,  1'b0, 1'b1, 1'b0, EE);         // clr on the set edge
        add(4'b0000, 1'b0, 4'd0,  1'b0, 1'b1, 1'b0, EE);
        add(4'b0000, 1'b0, 4'd0,  1'b0, 1'b1, 1'b0, EE);

        // Reset with g=0111 held.
        rst_n = 1'b0;
        g     = 4'b0111;
        clr   = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outs("por");
        rst_n = 1'b1;
        push_exp(edge_cnt + 1, 900, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        push_exp(edge_cnt + 2, 901, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);

        for (int i = 0; i < tbl.size(); i++) begin
            g   = tbl[i].g;
            clr = tbl[i].clr;
            push_exp(edge_cnt + 3, i, tbl[i].b, tbl[i].bv, tbl[i].dir, tbl[i].wrap, tbl[i].err);
            @(negedge clk);
        end
        clr = 1'b0;
        drain();

        // Move to 15 (dir=0), then start 15->14 and reset one edge later.
        g = 4'b1000;
        push_exp(edge_cnt + 3, 910, 4'd15, 1'b1, 1'b0, 1'b1, EE);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            push_exp(edge_cnt + 3, 911 + i, 4'd15, 1'b0, 1'b0, 1'b0, EE);
        end
        drain();
        g = 4'b1001;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_reset_outs("rst_mid");
        repeat (2) @(negedge clk);
        chk_reset_outs("rst_hold");
        rst_n = 1'b1;
        push_exp(edge_cnt + 1, 920, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        push_exp(edge_cnt + 2, 921, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 3; i <= 6; i++)
            push_exp(edge_cnt + i, 919 + i, 4'd14, 1'b0, 1'b1, 1'b0, 1'b0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
